// File: rtl/conv_seq_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed convolution stage.
// Saturation and ReLU work on a fixed wide signed type; callers truncate the result.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SAT_W = 128;

  function automatic int acc_w(input int bitwidth, input int terms);
    return 2 * bitwidth + $clog2(terms);
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int bitwidth);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (bitwidth - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [SAT_W-1:0] relu(input logic signed [SAT_W-1:0] v,
                                                   input logic en);
    return (en && v[SAT_W-1]) ? '0 : v;
  endfunction

endpackage

// File: rtl/conv_seq_if.sv
// Bus between the pooling stage (master) and the sequential conv layer (slave).
interface conv_seq_if #(
  parameter int BITWIDTH = 32,
  parameter int IN_CH    = 2,
  parameter int K        = 5,
  parameter int OUT_CH   = 10
);
  // start is taken only while busy=0 and done=0; busy stays high for the whole
  // computation and done pulses one cycle once every featuremap_out word is final.
  logic                       start;
  logic                       relu_en;
  logic signed [BITWIDTH-1:0] featuremap_in  [IN_CH][K][K];
  logic signed [BITWIDTH-1:0] kernel         [OUT_CH][IN_CH][K][K];
  logic signed [BITWIDTH-1:0] featuremap_out [OUT_CH];
  logic                       busy;
  logic                       done;

  modport master (output start, relu_en, featuremap_in, kernel,
                  input  featuremap_out, busy, done);
  modport slave  (input  start, relu_en, featuremap_in, kernel,
                  output featuremap_out, busy, done);
endinterface

// File: rtl/conv_mac_unit.sv
// Single shared multiply-accumulate: full-width signed product added to the
// running sum, with the sum restarted from zero on the first term of a channel.
module conv_mac_unit #(
  parameter int BITWIDTH = 32,
  parameter int ACC_W    = 70
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_en,
  input  logic                       i_first,
  input  logic signed [BITWIDTH-1:0] i_fm,
  input  logic signed [BITWIDTH-1:0] i_kw,
  output logic signed [ACC_W-1:0]    o_acc_next,
  output logic signed [ACC_W-1:0]    o_acc
);
  logic signed [2*BITWIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]      w_base;
  logic signed [ACC_W-1:0]      r_acc;

  assign w_prod     = i_fm * i_kw;
  assign w_base     = i_first ? '0 : r_acc;
  assign o_acc_next = w_base + ACC_W'(w_prod);
  assign o_acc      = r_acc;

  always_ff @(posedge clk) begin
    if (rst || i_clr) r_acc <= '0;
    else if (i_en)    r_acc <= o_acc_next;
  end
endmodule

// File: rtl/conv_layer_seq.sv
// Sequential conv layer: walks oc/ic/row/col through one MAC per cycle and
// writes each output channel, saturated and optionally rectified, on its last term.
module conv_layer_seq
  import conv_seq_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int IN_CH    = 2,
  parameter int K        = 5,
  parameter int OUT_CH   = 10
) (
  input  logic         clk,
  input  logic         rst,
  conv_seq_if.slave    bus,
  output state_t       o_dbg_state
);
  localparam int TERMS = IN_CH * K * K;
  localparam int ACC_W = acc_w(BITWIDTH, TERMS);
  localparam int OC_W  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int IC_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int K_W   = (K > 1) ? $clog2(K) : 1;
  localparam logic [OC_W-1:0] OC_LAST = OC_W'(OUT_CH - 1);
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(IN_CH - 1);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(K - 1);

  if (BITWIDTH < 1 || IN_CH < 1 || K < 1 || OUT_CH < 1 || ACC_W > SAT_W) begin : g_bad_params
    $error("conv_layer_seq: illegal parameter set");
  end

  state_t                     r_state, w_state_next;
  logic                       w_accept, w_busy, w_done;
  logic                       r_relu;
  logic [OC_W-1:0]            r_oc;
  logic [IC_W-1:0]            r_ic;
  logic [K_W-1:0]             r_row, r_col;
  logic signed [BITWIDTH-1:0] r_out [OUT_CH];
  logic                       w_first, w_last_term, w_last_all;
  logic signed [ACC_W-1:0]    w_acc_next, w_acc;

  assign w_first     = (r_ic == '0) && (r_row == '0) && (r_col == '0);
  assign w_last_term = (r_ic == IC_LAST) && (r_row == K_LAST) && (r_col == K_LAST);
  assign w_last_all  = w_last_term && (r_oc == OC_LAST);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_accept     = 1'b1;
        w_state_next = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last_all) w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // col is innermost; each wrap carries into the next-outer counter.
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_oc   <= '0;
      r_ic   <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_relu <= rst ? 1'b0 : bus.relu_en;
    end else if (w_busy) begin
      if (r_col == K_LAST) begin
        r_col <= '0;
        if (r_row == K_LAST) begin
          r_row <= '0;
          if (r_ic == IC_LAST) begin
            r_ic <= '0;
            r_oc <= (r_oc == OC_LAST) ? '0 : r_oc + 1'b1;
          end else begin
            r_ic <= r_ic + 1'b1;
          end
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  conv_mac_unit #(.BITWIDTH(BITWIDTH), .ACC_W(ACC_W)) u_mac (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_accept),
    .i_en       (w_busy),
    .i_first    (w_first),
    .i_fm       (bus.featuremap_in[r_ic][r_row][r_col]),
    .i_kw       (bus.kernel[r_oc][r_ic][r_row][r_col]),
    .o_acc_next (w_acc_next),
    .o_acc      (w_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUT_CH; i++) r_out[i] <= '0;
    end else if (w_busy && w_last_term) begin
      r_out[r_oc] <= BITWIDTH'(relu(saturate(SAT_W'(w_acc_next), BITWIDTH), r_relu));
    end
  end

  assign bus.featuremap_out = r_out;
  assign bus.busy           = w_busy;
  assign bus.done           = w_done;
  assign o_dbg_state        = r_state;

  logic w_unused;
  assign w_unused = ^w_acc;
endmodule
